if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 128 ++++++++++++
 tb/tb_if_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch front end. Issues one request at a time to instruction
//   memory, buffers returned words in a 2-entry FIFO and presents the FIFO
//   head to the IF/ID register. Redirects flush the buffer and poison any
//   request still in flight.
//
// Ports
//   clk, reset            clock, async active-low reset
//   imem_req_valid/addr   fetch request (addr = fetch PC, word aligned)
//   imem_req_ready        memory accepts request
//   imem_resp_valid/inst  returned instruction, no backpressure
//   stall                 IF/ID hold; head is not consumed this edge
//   redirect_valid/pc     branch-taken / flush target
//   Inst_IF, PC_out_IF    head instruction and its address (0 when empty)
//   Add_4_IF              PC_out_IF + 4 (0 when empty)
//   if_valid              head holds a real instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_inst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [31:0] Inst_IF,
    output logic [63:0] PC_out_IF,
    output logic [63:0] Add_4_IF,
    output logic        if_valid
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    // FETCH: idle, WAIT: response will be kept, DROP: response is stale
    typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } fetch_entry_t;

    state_t       state;
    logic [63:0]  pc_q;
    logic [63:0]  req_pc;
    fetch_entry_t fifo [FIFO_DEPTH];
    fetch_entry_t head;
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   occ;

    logic         in_wait;
    logic         pop;
    logic         push;
    logic         hs;
    logic [2:0]   occ_proj;
    logic         unused_rpc_lsb;

    assign in_wait = (state == WAIT);
    assign pop     = (occ != 2'd0) && !stall;
    assign push    = in_wait && imem_resp_valid;

    // Occupancy after this edge if the in-flight WAIT response lands; a new
    // request is only allowed when its response is guaranteed a slot.
    assign occ_proj = {1'b0, occ} + {2'b00, in_wait} - {2'b00, pop};

    // Gated by reset so the port reads 0 while reset is held.
    assign imem_req_valid = reset && !redirect_valid
                          && ((state == FETCH) || imem_resp_valid)
                          && (occ_proj < DEPTH);
    assign imem_req_addr  = pc_q;
    assign hs             = imem_req_valid && imem_req_ready;

    // Target is forced to word alignment, low bits intentionally ignored.
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc_q   <= RESET_PC & ~64'h3;
            req_pc <= '0;
            occ    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
        end else if (redirect_valid) begin
            // Flush wins over stall/push/pop; a response landing now is lost.
            occ    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            pc_q   <= {redirect_pc[63:2], 2'b00};
            state  <= (state != FETCH && !imem_resp_valid) ? DROP : FETCH;
        end else begin
            if (hs) begin
                req_pc <= pc_q;
                pc_q   <= pc_q + 64'd4;
            end
            if (push) begin
                fifo[wr_ptr] <= {imem_resp_inst, req_pc};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: ;
            endcase
            case (state)
                FETCH:      if (hs) state <= WAIT;
                WAIT, DROP: if (imem_resp_valid) state <= hs ? WAIT : FETCH;
                default:    state <= FETCH;
            endcase
        end
    end

    assign head      = fifo[rd_ptr];
    assign if_valid  = (occ != 2'd0);
    assign Inst_IF   = if_valid ? head.inst : '0;
    assign PC_out_IF = if_valid ? head.pc : '0;
    assign Add_4_IF  = if_valid ? head.pc + 64'd4 : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] Inst_IF;
    logic [63:0] PC_out_IF;
    logic [63:0] Add_4_IF;
    logic        if_valid;

    if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .Inst_IF(Inst_IF), .PC_out_IF(PC_out_IF), .Add_4_IF(Add_4_IF),
        .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: one outstanding request, latency lat_min..lat_max cycles.
    bit          mem_busy = 0;
    bit          mem_live = 0;   // cleared when a redirect makes it stale
    logic [63:0] mem_addr = '0;
    int          mem_cnt  = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;

    // Reference: addresses of buffered instructions (head first) and next fetch PC.
    logic [63:0] q[$];
    logic [63:0] exp_fetch = RST_PC;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with stall/redirect/ready already set.
    task automatic settle();
        logic exp_rv;
        logic pop_m;
        int   wait_m;
        imem_resp_valid = mem_busy && (mem_cnt == 0);
        imem_resp_inst  = imem_resp_valid ? inst_of(mem_addr) : 32'($urandom);
        #1;
        pop_m  = (q.size() > 0) && !stall;
        wait_m = (mem_busy && mem_live) ? 1 : 0;
        exp_rv = reset && !redirect_valid && (!mem_busy || imem_resp_valid)
                 && ((q.size() + wait_m - int'(pop_m)) < 2);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, exp_fetch);
        chk("if_valid", if_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("pc_out", PC_out_IF, q[0]);
            chk("inst", Inst_IF, inst_of(q[0]));
            chk("add4", Add_4_IF, q[0] + 64'd4);
        end else begin
            chk("pc_out_zero", PC_out_IF, 0);
            chk("inst_zero", Inst_IF, 0);
            chk("add4_zero", Add_4_IF, 0);
        end
    endtask

    task automatic tick();
        bit          hs, resp, redir, pop_m;
        logic [63:0] rpc;
        hs    = imem_req_valid && imem_req_ready;
        resp  = imem_resp_valid;
        redir = redirect_valid;
        rpc   = redirect_pc;
        pop_m = (q.size() > 0) && !stall;
        @(posedge clk);
        if (redir) begin
            q.delete();
            exp_fetch = {rpc[63:2], 2'b00};
        end else begin
            if (pop_m) q.delete(0);
            if (resp && mem_live) q.push_back(mem_addr);
        end
        if (resp) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (redir) mem_live = 0;
        if (hs) begin
            mem_busy  = 1;
            mem_live  = 1;
            mem_addr  = exp_fetch;
            mem_cnt   = int'($urandom_range(lat_max - 1, lat_min - 1));
            exp_fetch = exp_fetch + 64'd4;
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    initial begin
        int          n;
        logic [63:0] held_pc;
        reset = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_inst = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);

        // Reset state
        settle();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_pc_out", PC_out_IF, 0);
        tick();
        cyc();

        // Release: 0,4,8 on consecutive cycles, first instruction 2 cycles later
        reset = 1'b1;
        settle(); chk("c1_addr", imem_req_addr, 64'h0); chk("c1_vld", imem_req_valid, 1);
        chk("c1_ifv", if_valid, 0); tick();
        settle(); chk("c2_addr", imem_req_addr, 64'h4); chk("c2_vld", imem_req_valid, 1);
        chk("c2_ifv", if_valid, 0); tick();
        settle(); chk("c3_addr", imem_req_addr, 64'h8); chk("c3_ifv", if_valid, 1);
        chk("c3_pc", PC_out_IF, 64'h0); chk("c3_add4", Add_4_IF, 64'h4); tick();
        settle(); chk("c4_ifv", if_valid, 1); chk("c4_pc", PC_out_IF, 64'h4); tick();

        // Stall until the buffer is full, hold 5 cycles, then drain
        stall = 1'b1;
        n = 0;
        while (!(q.size() == 2 && !mem_busy) && n < 10) begin cyc(); n++; end
        chk("fill_timeout", (q.size() == 2 && !mem_busy), 1);
        held_pc = q[0];
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("hold_req_valid", imem_req_valid, 0);
            chk("hold_pc", PC_out_IF, held_pc);
            tick();
        end
        stall = 1'b0;
        settle(); chk("drain0_pc", PC_out_IF, held_pc);
        chk("resume_addr", imem_req_addr, held_pc + 64'd8);
        chk("resume_vld", imem_req_valid, 1); tick();
        settle(); chk("drain1_pc", PC_out_IF, held_pc + 64'd4); tick();

        // Redirect while 0x8 is outstanding, response next cycle
        redirect_valid = 1'b1; redirect_pc = 64'h0; cyc();
        redirect_valid = 1'b0; lat_min = 2; lat_max = 2;
        n = 0;
        while (!(mem_busy && mem_live && mem_addr == 64'h8 && mem_cnt > 0) && n < 30) begin
            cyc(); n++;
        end
        chk("wait8_timeout", (mem_busy && mem_addr == 64'h8), 1);
        redirect_valid = 1'b1; redirect_pc = 64'h100; cyc();
        redirect_valid = 1'b0;
        settle(); chk("drop8_resp", imem_resp_valid, 1);
        chk("redir_addr", imem_req_addr, 64'h100); chk("redir_vld", imem_req_valid, 1); tick();
        for (int i = 0; i < 8; i++) begin
            settle(); chk("no_0x8", (if_valid && PC_out_IF == 64'h8), 0); tick();
        end

        // Redirect coinciding with a response, unaligned target
        lat_min = 1; lat_max = 1;
        n = 0;
        while (!(mem_busy && mem_live && mem_cnt == 0) && n < 10) begin cyc(); n++; end
        chk("resp_timeout", (mem_busy && mem_cnt == 0), 1);
        redirect_valid = 1'b1; redirect_pc = 64'h203; cyc();
        redirect_valid = 1'b0;
        settle(); chk("r203_addr", imem_req_addr, 64'h200); chk("r203_vld", imem_req_valid, 1);
        chk("r203_ifv", if_valid, 0); tick();

        // Wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; cyc();
        redirect_valid = 1'b0;
        settle(); chk("top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC); tick();
        settle(); chk("wrap_addr", imem_req_addr, 64'h0); tick();
        n = 0;
        while (!(if_valid && PC_out_IF == 64'hFFFF_FFFF_FFFF_FFFC) && n < 10) begin cyc(); n++; end
        chk("top_ifv", (if_valid && PC_out_IF == 64'hFFFF_FFFF_FFFF_FFFC), 1);
        chk("wrap_add4", Add_4_IF, 64'h0);
        cyc();

        // Asynchronous reset mid-cycle while a request is outstanding
        lat_min = 3; lat_max = 3;
        n = 0;
        while (!(mem_busy && mem_live && mem_cnt > 0) && n < 10) begin cyc(); n++; end
        chk("wait_timeout", (mem_busy && mem_live), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_req_valid", imem_req_valid, 0);
        chk("arst_if_valid", if_valid, 0);
        chk("arst_inst", Inst_IF, 0);
        chk("arst_pc", PC_out_IF, 0);
        chk("arst_add4", Add_4_IF, 0);
        q.delete(); mem_busy = 0; mem_live = 0; exp_fetch = RST_PC; imem_resp_valid = 1'b0;
        @(negedge clk);
        cyc();
        reset = 1'b1;
        settle(); chk("restart_addr", imem_req_addr, RST_PC); chk("restart_vld", imem_req_valid, 1); tick();

        // Randomized traffic against the reference model
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom_range(99) < 75);
            stall          = ($urandom_range(99) < 30);
            redirect_valid = ($urandom_range(99) < 5);
            case ($urandom_range(2))
                0:       redirect_pc = {$urandom, $urandom};
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
                default: redirect_pc = 64'($urandom_range(4095));
            endcase
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
